mastermind_turn_timer: RTL and testbench
========================================

// Module: mastermind_turn_timer
//
// PURPOSE
//   Per-turn countdown timer for the Mastermind game.
//   - Consumes the one-cycle tick pulse from the slow clock divider (one pulse every 1,000,000 clocks).
//   - Counts whole seconds down from TURN_SECONDS and drives BCD digits to the HEX display.
//   - Flags the low-time warning and pulses timeout to the game controller when the turn expires.
//
// PARAMETERS
//   TICKS_PER_SEC  50  tick pulses per displayed second (>=1)
//   TURN_SECONDS   30  seconds per turn, reload value (1..99)
//   WARN_SECONDS    5  warning asserted while secs <= this and timer active (< TURN_SECONDS)
//
// PORTS
//   clock       in   1  system clock; all logic on its posedge
//   reset_n     in   1  synchronous reset, active-low
//   tick        in   1  one-cycle enable pulse from the slow clock divider
//   start       in   1  pulse: load TURN_SECONDS and run
//   pause       in   1  pulse: toggle RUNNING <-> PAUSED
//   guess_done  in   1  pulse: player submitted guess; stop and reload
//   running     out  1  state == RUNNING
//   expired     out  1  state == EXPIRED
//   timeout     out  1  one-cycle pulse on entry to EXPIRED
//   warning     out  1  (RUNNING|PAUSED) && secs <= WARN_SECONDS
//   blink       out  1  display-flash qualifier (see CONFIGURATION)
//   secs_tens   out  4  BCD tens of secs
//   secs_ones   out  4  BCD ones of secs
//
// BEHAVIOUR
//   - Registers:
//     - state {IDLE, RUNNING, PAUSED, EXPIRED}.
//     - secs 7b.
//     - sub, the tick counter 0..TICKS_PER_SEC-1.
//   - Reset (reset_n=0 at a clock edge, including mid-run):
//     - state=IDLE, secs=TURN_SECONDS, sub=0.
//     - running=expired=timeout=warning=blink=0.
//     - BCD shows TURN_SECONDS.
//   - Per-cycle input priority: guess_done > start > pause > tick. Lower-priority inputs in the same cycle are ignored.
//   - IDLE:
//     - start -> RUNNING, secs=TURN_SECONDS, sub=0.
//     - All other inputs ignored.
//   - RUNNING, tick:
//     - If sub < TICKS_PER_SEC-1, then sub++.
//     - Otherwise sub=0 and secs--.
//     - If the decrement makes secs 0: state=EXPIRED, timeout=1 for exactly the next cycle.
//   - RUNNING, other inputs:
//     - pause -> PAUSED; sub and secs are held.
//     - start -> restart: secs=TURN_SECONDS, sub=0, stay RUNNING.
//     - guess_done -> IDLE, secs=TURN_SECONDS, sub=0.
//   - PAUSED:
//     - tick ignored.
//     - pause -> RUNNING, resuming with the held sub.
//     - start / guess_done as in RUNNING (restart / go IDLE).
//   - EXPIRED:
//     - secs held at 0; ticks and pause ignored.
//     - start -> RUNNING with reload.
//     - guess_done -> IDLE with reload.
//   - Outputs:
//     - running, expired, warning and the BCD digits are decoded from the registered state and secs. No extra latency: they change in the cycle after the causing edge.
//     - secs_tens = secs/10; secs_ones = secs%10. Neither digit ever exceeds 9.
//   - Boundaries:
//     - TICKS_PER_SEC=1: every tick decrements secs.
//     - TURN_SECONDS=1: the first full second expires the turn.
//     - tick arriving on a start cycle is dropped; sub starts at 0.
//     - guess_done on the same cycle as the final tick: IDLE, no timeout pulse.
//
// CONFIGURATION
//   MASTERMIND_TIMER_BLINK_EN
//     - defined: blink = warning && (sub < TICKS_PER_SEC/2), i.e. the display flashes at 1 Hz during warning.
//       With TICKS_PER_SEC=1, blink = warning.
//     - undefined: blink = warning (steady); no extra logic.
//
// TESTING  (bench params: TICKS_PER_SEC=4, TURN_SECONDS=12, WARN_SECONDS=5)
//   1. Reset held 2 cycles -> tens=1, ones=2; running=expired=timeout=warning=blink=0.
//   2. start, then 4 ticks -> after the 4th tick edge: tens=1, ones=1, running=1.
//   3. start + 48 ticks -> timeout high exactly 1 cycle, expired=1, BCD 0/0.
//      warning rises when secs hits 5. 10 further ticks -> no change.
//   4. start, 2 ticks, pause, 10 ticks, pause, 2 ticks -> secs=11.
//      running=0 only while paused.
//   5. Run to secs=1, sub=3; assert guess_done and tick together -> IDLE, BCD 1/2, no timeout pulse.
//   6. reset_n=0 for 1 cycle while RUNNING at secs=4 -> next cycle all reset values.
//      With BLINK_EN, blink follows the sub<2 pattern before the reset.

Source files
------------

// File: rtl/mastermind_turn_timer.sv
// Per-turn countdown timer: counts whole seconds of slow-divider ticks down from TURN_SECONDS, drives BCD digits, warns and times out.
// Optional feature macro: MASTERMIND_TIMER_BLINK_EN (flash the warning at 1 Hz via blink).
module mastermind_turn_timer #(
   parameter int TICKS_PER_SEC = 50,
   parameter int TURN_SECONDS  = 30,
   parameter int WARN_SECONDS  = 5
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic       guess_done,
   output logic       running,
   output logic       expired,
   output logic       timeout,
   output logic       warning,
   output logic       blink,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic [1:0] o_dbg_state
);

   localparam int              SUB_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [6:0]       SECS_RELOAD = 7'(TURN_SECONDS);
   localparam logic [6:0]       SECS_WARN   = 7'(WARN_SECONDS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [6:0]       r_secs;
   logic [6:0]       w_secs_nxt;
   logic [SUB_W-1:0] r_sub;
   logic [SUB_W-1:0] w_sub_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;
   logic             w_warning;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_secs    <= SECS_RELOAD;
         r_sub     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_secs    <= w_secs_nxt;
         r_sub     <= w_sub_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // Inputs are strictly prioritised: guess_done > start > pause > tick.
   always_comb begin
      w_state_nxt   = r_state;
      w_secs_nxt    = r_secs;
      w_sub_nxt     = r_sub;
      w_timeout_nxt = 1'b0;
      if (guess_done) begin
         w_state_nxt = S_IDLE;
         w_secs_nxt  = SECS_RELOAD;
         w_sub_nxt   = '0;
      end else if (start) begin
         w_state_nxt = S_RUNNING;
         w_secs_nxt  = SECS_RELOAD;
         w_sub_nxt   = '0;
      end else if (pause) begin
         if (r_state == S_RUNNING) begin
            w_state_nxt = S_PAUSED;
         end else if (r_state == S_PAUSED) begin
            w_state_nxt = S_RUNNING;
         end
      end else if (tick && (r_state == S_RUNNING)) begin
         if (r_sub != SUB_LAST) begin
            w_sub_nxt = r_sub + 1'b1;
         end else begin
            w_sub_nxt  = '0;
            w_secs_nxt = r_secs - 7'd1;
            if (r_secs == 7'd1) begin
               w_state_nxt   = S_EXPIRED;
               w_timeout_nxt = 1'b1;
            end
         end
      end
   end

   assign running     = (r_state == S_RUNNING);
   assign expired     = (r_state == S_EXPIRED);
   assign timeout     = r_timeout;
   assign w_warning   = ((r_state == S_RUNNING) || (r_state == S_PAUSED)) && (r_secs <= SECS_WARN);
   assign warning     = w_warning;
   assign secs_tens   = 4'(r_secs / 7'd10);
   assign secs_ones   = 4'(r_secs % 7'd10);
   assign o_dbg_state = r_state;

`ifdef MASTERMIND_TIMER_BLINK_EN
   // Lit for the first half of each second, so the digits flash at 1 Hz.
   if (TICKS_PER_SEC == 1) begin : g_blink_steady
      assign blink = w_warning;
   end else begin : g_blink_flash
      assign blink = w_warning && (r_sub < SUB_W'(TICKS_PER_SEC / 2));
   end
`else
   assign blink = w_warning;
`endif

endmodule

// File: tb/tb_mastermind_turn_timer.sv
// Bench for mastermind_turn_timer: directed scenarios then random stimulus against an elapsed-tick reference model.
module tb_mastermind_turn_timer;

  localparam int TPS  = 4;
  localparam int TURN = 12;
  localparam int WARN = 5;
  localparam int W    = 13;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       guess_done = 1'b0;
  logic       running, expired, timeout, warning, blink;
  logic [3:0] secs_tens, secs_ones;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model: mode is 'I'dle, 'R'unning, 'P'aused, 'E'xpired; time kept as ticks elapsed since load
  byte m_mode = "I";
  int  m_elapsed = 0;
  bit  m_timeout = 1'b0;
  logic [W-1:0] exp_q[$];

  mastermind_turn_timer #(
    .TICKS_PER_SEC(TPS),
    .TURN_SECONDS(TURN),
    .WARN_SECONDS(WARN)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tick(tick),
    .start(start),
    .pause(pause),
    .guess_done(guess_done),
    .running(running),
    .expired(expired),
    .timeout(timeout),
    .warning(warning),
    .blink(blink),
    .secs_tens(secs_tens),
    .secs_ones(secs_ones),
    .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic model_step(input bit rst, input bit gd, input bit st, input bit pa, input bit tk);
    int secs, sub;
    bit warn, blk;
    m_timeout = 1'b0;
    if (rst) begin
      m_mode = "I"; m_elapsed = 0;
    end else if (gd) begin
      m_mode = "I"; m_elapsed = 0;
    end else if (st) begin
      m_mode = "R"; m_elapsed = 0;
    end else if (pa) begin
      if (m_mode == "R") m_mode = "P";
      else if (m_mode == "P") m_mode = "R";
    end else if (tk && m_mode == "R") begin
      m_elapsed++;
      if (m_elapsed == TURN * TPS) begin
        m_mode = "E"; m_timeout = 1'b1;
      end
    end
    secs = TURN - m_elapsed / TPS;
    sub  = m_elapsed % TPS;
    warn = (m_mode == "R" || m_mode == "P") && secs <= WARN;
`ifdef MASTERMIND_TIMER_BLINK_EN
    blk = warn && (TPS == 1 || sub < TPS / 2);
`else
    blk = warn;
`endif
    exp_q.push_back({m_mode == "R", m_mode == "E", m_timeout, warn, blk, 4'(secs / 10), 4'(secs % 10)});
  endtask

  // Inputs are driven 1 time unit after a rising edge and sampled after the next one.
  task automatic step(input bit rst, input bit gd, input bit st, input bit pa, input bit tk);
    logic [W-1:0] e;
    reset_n = ~rst; guess_done = gd; start = st; pause = pa; tick = tk;
    @(posedge clock);
    #1;
    cyc++;
    model_step(rst, gd, st, pa, tk);
    reset_n = 1'b1; guess_done = 0; start = 0; pause = 0; tick = 0;
    e = exp_q.pop_front();
    check("running", running, e[12]);
    check("expired", expired, e[11]);
    check("timeout", timeout, e[10]);
    check("warning", warning, e[9]);
    check("blink",   blink,   e[8]);
    check("tens",    secs_tens, e[7:4]);
    check("ones",    secs_ones, e[3:0]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    // reset held two cycles
    @(posedge clock); #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // start then one full second
    step(0, 0, 1, 0, 0);
    ticks(4);
    // full turn to expiry, then ticks and pause while expired are ignored
    step(0, 0, 1, 0, 0);
    ticks(48);
    step(0, 0, 0, 0, 0);
    ticks(10);
    step(0, 0, 0, 1, 0);
    // pause freezes the count
    step(0, 0, 1, 0, 0);
    ticks(2);
    step(0, 0, 0, 1, 0);
    ticks(10);
    step(0, 0, 0, 1, 0);
    ticks(2);
    // guess_done coincides with the final tick: no timeout
    step(0, 0, 1, 0, 0);
    ticks(47);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // tick on a start cycle is dropped
    step(0, 0, 1, 0, 1);
    ticks(3);
    // reset mid-run at secs=4
    step(0, 0, 1, 0, 0);
    ticks(34);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_gd, r_st, r_pa, r_tk;
      r_rst = ($urandom_range(0, 399) == 0);
      r_gd  = ($urandom_range(0, 119) == 0);
      r_st  = ($urandom_range(0, 79) == 0);
      r_pa  = ($urandom_range(0, 39) == 0);
      r_tk  = ($urandom_range(0, 9) < 6);
      step(r_rst, r_gd, r_st, r_pa, r_tk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
